// File: rtl/spi_pkg.sv
// Shared types and helpers for the SPI counter-link receiver.
package spi_pkg;

  localparam int CNT_W  = 14;
  localparam int HI_TAG = 7;

  typedef logic [7:0] byte_t;

  typedef enum logic {
    EXPECT_HI,
    EXPECT_LO
  } pair_state_e;

  function automatic logic [CNT_W-1:0] pair_value(input logic [6:0] hi, input logic [6:0] lo);
    return {hi, lo};
  endfunction

endpackage

// File: rtl/spi_sync_edge.sv
// Multi-flop synchronizer with a registered delay tap for rise/fall detection.
module spi_sync_edge #(
  parameter int   STAGES = 2,
  parameter logic INIT   = 1'b0
) (
  input  logic clk,
  input  logic reset,
  input  logic din,
  output logic dout,
  output logic rise,
  output logic fall
);

  logic [STAGES-1:0] sync_p;
  logic              prev;

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      sync_p <= {STAGES{INIT}};
      prev   <= INIT;
    end else begin
      sync_p <= {sync_p[STAGES-2:0], din};
      prev   <= sync_p[STAGES-1];
    end
  end

  assign dout = sync_p[STAGES-1];
  assign rise = dout & ~prev;
  assign fall = ~dout & prev;

endmodule

// File: rtl/spi_slave_rx_decoder.sv
// SPI mode-0 slave: receives tagged hi/lo byte pairs into a 0..CNT_MAX counter value
// and returns a status byte on miso.
module spi_slave_rx_decoder
  import spi_pkg::*;
#(
  parameter int SYNC_STAGES = 2,
  parameter int CNT_MAX     = 9999
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             sclk,
  input  logic             mosi,
  input  logic             ss_n,
  output logic             miso,
  input  logic [7:0]       tx_data,
  output logic [7:0]       rx_data,
  output logic             rx_valid,
  output logic [CNT_W-1:0] counter,
  output logic             counter_valid,
  output logic             frame_err
);

  localparam logic [CNT_W-1:0] CNT_LIMIT = CNT_W'(CNT_MAX);

  logic sclk_s, sclk_rise, sclk_fall;
  logic ss_s, ss_rise, ss_fall;
  logic mosi_s, mosi_rise_unused, mosi_fall_unused;

  spi_sync_edge #(.STAGES(SYNC_STAGES), .INIT(1'b0)) u_sclk (
    .clk(clk), .reset(reset), .din(sclk), .dout(sclk_s), .rise(sclk_rise), .fall(sclk_fall)
  );
  spi_sync_edge #(.STAGES(SYNC_STAGES), .INIT(1'b1)) u_ss (
    .clk(clk), .reset(reset), .din(ss_n), .dout(ss_s), .rise(ss_rise), .fall(ss_fall)
  );
  spi_sync_edge #(.STAGES(SYNC_STAGES), .INIT(1'b0)) u_mosi (
    .clk(clk), .reset(reset), .din(mosi), .dout(mosi_s),
    .rise(mosi_rise_unused), .fall(mosi_fall_unused)
  );

  function automatic logic in_range(input logic [CNT_W-1:0] v);
    return v <= CNT_LIMIT;
  endfunction

  logic [6:0]  shift_reg;
  logic [2:0]  bit_cnt, bit_cnt_next;
  byte_t       tx_shift;
  logic        tx_active;
  logic        shift_en, partial_err;

  // An ss_n rise in the same cycle as the 8th sclk rise still counts that bit,
  // so a byte closing exactly at frame end completes without error.
  assign shift_en     = sclk_rise & (~ss_s | ss_rise);
  assign bit_cnt_next = shift_en ? bit_cnt + 3'd1 : bit_cnt;
  assign partial_err  = ss_rise & (bit_cnt_next != 3'd0);
  assign miso         = tx_active & tx_shift[HI_TAG];

  // ---- bit engine and TX shifter ----
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      shift_reg <= '0;
      bit_cnt   <= '0;
      rx_data   <= '0;
      rx_valid  <= 1'b0;
      tx_shift  <= '0;
      tx_active <= 1'b0;
    end else begin
      rx_valid <= 1'b0;
      if (shift_en) begin
        shift_reg <= {shift_reg[5:0], mosi_s};
        if (bit_cnt == 3'd7) begin
          rx_data  <= {shift_reg, mosi_s};
          rx_valid <= 1'b1;
        end
      end
      bit_cnt <= (ss_fall | ss_rise) ? 3'd0 : bit_cnt_next;

      if (ss_fall) begin
        tx_shift  <= tx_data;
        tx_active <= 1'b1;
      end else if (ss_rise) begin
        tx_active <= 1'b0;
      end else if (sclk_fall && tx_active) begin
        tx_shift <= {tx_shift[6:0], 1'b0};
      end
    end
  end

  pair_state_e      state;
  logic [6:0]       hi;
  logic [CNT_W-1:0] value;

  assign value = pair_value(hi, rx_data[6:0]);

  // ---- pair FSM and range check ----
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state         <= EXPECT_HI;
      hi            <= '0;
      counter       <= '0;
      counter_valid <= 1'b0;
      frame_err     <= 1'b0;
    end else begin
      counter_valid <= 1'b0;
      frame_err     <= partial_err;
      if (rx_valid) begin
        case (state)
          EXPECT_HI: begin
            if (rx_data[HI_TAG]) begin
              hi    <= rx_data[6:0];
              state <= EXPECT_LO;
            end else begin
              frame_err <= 1'b1;
            end
          end
          EXPECT_LO: begin
            if (!rx_data[HI_TAG]) begin
              if (in_range(value)) begin
                counter       <= value;
                counter_valid <= 1'b1;
              end else begin
                frame_err <= 1'b1;
              end
              state <= EXPECT_HI;
            end else begin
              frame_err <= 1'b1;
              hi        <= rx_data[6:0];
            end
          end
          default: state <= EXPECT_HI;
        endcase
      end
    end
  end

endmodule

// File: doc/spi_slave_rx_decoder.md
# spi_slave_rx_decoder

SPI mode-0 slave receiver: the far end of the counter link from the up-counter/SPI master. Oversamples `sclk`/`mosi`/`ss_n` in the system clock domain and shifts bytes in MSB-first. Pairs the tagged high and low bytes into a 14-bit counter value (0..9999) for the FND driver, and shifts a status byte back on `miso`.

## Interface
- `SYNC_STAGES`, 2: synchronizer depth on `sclk`, `mosi`, `ss_n` (≥2).
- `CNT_MAX`, 9999: largest legal assembled counter value.
- `clk` in 1: system clock, 100 MHz.
- `reset` in 1: asynchronous, active-high; clears all state.
- `sclk` in 1: SPI clock from master, idle low (mode 0).
- `mosi` in 1: serial data from master, MSB first.
- `ss_n` in 1: active-low slave select.
- `miso` out 1: serial data to master; 0 while `ss_n` high.
- `tx_data` in 8: status byte, sampled at frame start.
- `rx_data` out 8: last complete received byte.
- `rx_valid` out 1: one-clk pulse per complete byte.
- `counter` out 14: last valid assembled value; holds between updates.
- `counter_valid` out 1: one-clk pulse when `counter` updates.
- `frame_err` out 1: one-clk pulse on any protocol violation.

## Operation
- Wire format: high byte = {1, count[13:7]}; low byte = {0, count[6:0]}. Bit 7 tags the byte, so the stream self-synchronizes. Bytes may share one `ss_n` window or use separate windows.
- Input path: each input passes through `SYNC_STAGES` flops, then an edge detect on synchronized `sclk` (rise/fall) and `ss_n` (fall = frame start, rise = frame end).
- Bit engine:
  - `sclk` rise with `ss_n` low: shift synchronized `mosi` into an 8-bit register and increment a 3-bit bit count.
  - When the count wraps 7→0: `rx_data` ← shifted byte, `rx_valid` pulses.
- Pair FSM, states EXPECT_HI and EXPECT_LO:
  - EXPECT_HI, bit7=1: store hi[6:0] → EXPECT_LO.
  - EXPECT_HI, bit7=0: `frame_err` pulse, byte discarded, stay.
  - EXPECT_LO, bit7=0: value = {hi, byte[6:0]}. If ≤ `CNT_MAX`: `counter` ← value and `counter_valid` pulses. Otherwise `frame_err` pulses and `counter` holds. Either way → EXPECT_HI.
  - EXPECT_LO, bit7=1: `frame_err` pulse, hi replaced by the new byte, stay in EXPECT_LO.
- MISO path:
  - `ss_n` fall: load `tx_data` into the TX shift register; `miso` = bit 7.
  - Each `sclk` fall: shift left, fill with 0.
  - `ss_n` high: `miso` = 0.
- `ss_n` rise with bit count ≠ 0: partial byte discarded, bit count cleared, `frame_err` pulse, FSM state unchanged.
- `ss_n` fall: bit count cleared regardless of prior state.

## Timing
- Reset values: `miso`=0, `rx_data`=0, `rx_valid`=0, `counter`=0, `counter_valid`=0, `frame_err`=0. FSM = EXPECT_HI, bit count = 0, hi = 0.
- Supported `sclk`: period ≥ 8 clk cycles, high and low phases each ≥ 4 clk.
- `rx_valid`: SYNC_STAGES+1 clk after the 8th `sclk` rising edge at the pins (3 clk by default).
- `counter_valid`: 1 clk after the `rx_valid` of the low byte; `counter` updates in the same cycle.
- `miso`: changes SYNC_STAGES+1 clk after the `sclk` fall at the pins, well inside the master's half-period setup window.
- Simultaneous `ss_n` rise and 8th-bit `sclk` rise in the same synchronized cycle: the byte completes normally with no `frame_err`.
- Reset mid-byte or mid-pair: all partial state dropped. The next high byte starts cleanly.

## Structure
- Package `spi_pkg`:
  - `byte_t` (logic [7:0])
  - `pair_state_e` enum {EXPECT_HI, EXPECT_LO}
  - `CNT_W` = 14
  - `HI_TAG` = bit index 7
- Sub-module `spi_sync_edge`: parameterized synchronizer plus rise/fall edge detector. Three instances: `sclk`, `ss_n`, `mosi` (edges unused for `mosi`).
- Top holds the bit engine, TX shifter, pair FSM and range check.

## Test plan
- Reset, then frame bytes 0x80+(1234>>7)=0x89 and 0x52 (1234&0x7F) in one `ss_n` window → `counter`=1234, one `counter_valid` pulse, no `frame_err`.
- Same value sent as two separate `ss_n` windows → `counter`=1234.
- `tx_data`=0xA5 during frame → master samples 1010_0101 on `miso`. `miso`=0 after `ss_n` rises.
- Low byte 0x10 first, then 0x89, 0x52 → one `frame_err` on 0x10, then `counter`=1234.
- 0xFF, 0x7F (16383 > 9999) → `frame_err` pulse, `counter` keeps its previous value. `ss_n` raised after 5 bits → `frame_err`, no `rx_valid`.
- `reset` asserted between hi 0x89 and lo 0x52 → low byte alone yields `frame_err`, `counter`=0.
